traffic_lamp_monitor: RTL and testbench

- Conflict/malfunction monitor on the receiving end of the traffic controller's lamp outputs: samples main_R/G/Y and side_R/G/Y and checks that the displayed sequence is legal.
- Latches the first violation with a code and drives flash_red so the cabinet can force all-red flashing.
- Counts completed main-road cycles for status reporting.
- Same clock domain as the controller; inputs are used directly with no synchroniser.

---
 rtl/traffic_lamp_monitor.sv | 166 ++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_monitor.sv
// Lamp-sequence monitor for a two-approach traffic controller: tracks each approach,
// latches the first violation with a code and requests all-red flashing.
module traffic_lamp_monitor #(
  parameter int unsigned MIN_YEL_CYC  = 150000000,
  parameter logic [3:0]  CONFLICT_CYC = 4'd2,
  parameter logic [3:0]  GLITCH_CYC   = 4'd3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        main_R,
  input  logic        main_G,
  input  logic        main_Y,
  input  logic        side_R,
  input  logic        side_G,
  input  logic        side_Y,
  input  logic        clear_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        flash_red,
  output logic [15:0] main_cycles
);

  typedef enum logic [1:0] {UNK = 2'd0, RED = 2'd1, GRN = 2'd2, YEL = 2'd3} lamp_st_t;

  localparam int unsigned NAPP = 2;

  logic [2:0]       lamps   [NAPP];
  logic             vld     [NAPP];
  lamp_st_t         dec     [NAPP];
  lamp_st_t         st_q    [NAPP];
  lamp_st_t         st_d    [NAPP];
  logic [CNT_W-1:0] yc_q    [NAPP];
  logic [CNT_W-1:0] yc_d    [NAPP];
  logic             timed_q [NAPP];
  logic             timed_d [NAPP];
  logic             illegal [NAPP];
  logic             short_y [NAPP];
  logic             main_done;
  logic [3:0]       conf_q, conf_d, lamp_q, lamp_d;
  logic             both_act, any_inv;
  logic             conf_hit, lamp_hit;
  logic [2:0]       viol_code;

  function automatic logic is_illegal(input lamp_st_t cur, input lamp_st_t nxt);
    return (cur == GRN && nxt == RED) || (cur == RED && nxt == YEL) ||
           (cur == YEL && nxt == GRN);
  endfunction

  // Per-approach one-hot decode: exactly one lamp lit is a valid state.
  always_comb begin
    lamps[0] = {main_R, main_G, main_Y};
    lamps[1] = {side_R, side_G, side_Y};
    for (int i = 0; i < NAPP; i++) begin
      vld[i] = 1'b1;
      dec[i] = UNK;
      case (lamps[i])
        3'b100:  dec[i] = RED;
        3'b010:  dec[i] = GRN;
        3'b001:  dec[i] = YEL;
        default: vld[i] = 1'b0;
      endcase
    end
  end

  // Tracker, yellow timer and counter state register.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NAPP; i++) begin
        st_q[i]    <= UNK;
        yc_q[i]    <= '0;
        timed_q[i] <= 1'b0;
      end
      conf_q <= '0;
      lamp_q <= '0;
    end else begin
      st_q    <= st_d;
      yc_q    <= yc_d;
      timed_q <= timed_d;
      conf_q  <= conf_d;
      lamp_q  <= lamp_d;
    end
  end

  // Next-state: invalid samples hold; only GRN->YEL starts a timed yellow.
  always_comb begin
    main_done = 1'b0;
    for (int i = 0; i < NAPP; i++) begin
      st_d[i]    = st_q[i];
      yc_d[i]    = yc_q[i];
      timed_d[i] = timed_q[i];
      illegal[i] = 1'b0;
      short_y[i] = 1'b0;
      if (vld[i]) begin
        st_d[i] = dec[i];
        if (st_q[i] == UNK) begin
          yc_d[i]    = '0;
          timed_d[i] = 1'b0;
        end else if (dec[i] != st_q[i]) begin
          illegal[i] = is_illegal(st_q[i], dec[i]);
          yc_d[i]    = '0;
          timed_d[i] = 1'b0;
          if (st_q[i] == GRN && dec[i] == YEL) begin
            yc_d[i]    = CNT_W'(1);
            timed_d[i] = 1'b1;
          end else if (st_q[i] == YEL && dec[i] == RED && timed_q[i]) begin
            if (yc_q[i] < CNT_W'(MIN_YEL_CYC)) short_y[i] = 1'b1;
            else if (i == 0)                    main_done  = 1'b1;
          end
        end else if (st_q[i] == YEL && timed_q[i] && yc_q[i] != '1) begin
          yc_d[i] = yc_q[i] + CNT_W'(1);
        end
      end
    end

    both_act = (dec[0] == GRN || dec[0] == YEL) && (dec[1] == GRN || dec[1] == YEL);
    any_inv  = !vld[0] || !vld[1];
    conf_d   = both_act ? ((conf_q == 4'hF) ? conf_q : conf_q + 4'd1) : 4'd0;
    lamp_d   = any_inv  ? ((lamp_q == 4'hF) ? lamp_q : lamp_q + 4'd1) : 4'd0;

    if (clear_fault) begin
      for (int i = 0; i < NAPP; i++) begin
        st_d[i]    = UNK;
        yc_d[i]    = '0;
        timed_d[i] = 1'b0;
      end
      conf_d = '0;
      lamp_d = '0;
    end
  end

  // Violation detection with fixed priority 1 > 2 > 3 > 4 > 5 > 6.
  always_comb begin
    conf_hit  = both_act && (conf_d >= CONFLICT_CYC);
    lamp_hit  = any_inv && (lamp_d >= GLITCH_CYC);
    viol_code = 3'd0;
    if      (conf_hit)   viol_code = 3'd1;
    else if (illegal[0]) viol_code = 3'd2;
    else if (illegal[1]) viol_code = 3'd3;
    else if (short_y[0]) viol_code = 3'd4;
    else if (short_y[1]) viol_code = 3'd5;
    else if (lamp_hit)   viol_code = 3'd6;
  end

  // First fault wins until cleared; flash_red trails fault by one cycle.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      flash_red   <= 1'b0;
      main_cycles <= 16'd0;
    end else begin
      flash_red <= fault;
      if (clear_fault) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
      end else if (!fault && viol_code != 3'd0) begin
        fault      <= 1'b1;
        fault_code <= viol_code;
      end
      if (!clear_fault && !fault && main_done && main_cycles != 16'hFFFF)
        main_cycles <= main_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed scoreboard bench for traffic_lamp_monitor with short timing parameters.
module tb_traffic_lamp_monitor;

  localparam logic [2:0] LR   = 3'b100;
  localparam logic [2:0] LG   = 3'b010;
  localparam logic [2:0] LY   = 3'b001;
  localparam logic [2:0] LOFF = 3'b000;
  localparam logic [2:0] LRY  = 3'b101;

  typedef struct {
    logic        fault;
    logic [2:0]  code;
    logic        flash;
    logic [15:0] cycles;
  } exp_t;

  logic        clk_50, reset;
  logic        main_R, main_G, main_Y, side_R, side_G, side_Y, clear_fault;
  logic        fault, flash_red;
  logic [2:0]  fault_code;
  logic [15:0] main_cycles;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_fault;
  logic [15:0] exp_cycles;

  traffic_lamp_monitor #(
    .MIN_YEL_CYC (4),
    .CONFLICT_CYC(4'd2),
    .GLITCH_CYC  (4'd3),
    .CNT_W       (32)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .main_R     (main_R),
    .main_G     (main_G),
    .main_Y     (main_Y),
    .side_R     (side_R),
    .side_G     (side_G),
    .side_Y     (side_Y),
    .clear_fault(clear_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_red  (flash_red),
    .main_cycles(main_cycles)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  task automatic push_exp(input logic ef, input logic [2:0] ec);
    exp_t e;
    e.fault  = ef;
    e.code   = ec;
    e.flash  = reset ? 1'b0 : prev_fault;
    e.cycles = exp_cycles;
    sb.push_back(e);
    prev_fault = reset ? 1'b0 : ef;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s scoreboard: got empty queue want one entry", tag);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    assert (fault === e.fault) else begin
      n_fail++;
      $error("FAIL %s fault: got %0b want %0b", tag, fault, e.fault);
    end
    n_checks++;
    assert (fault_code === e.code) else begin
      n_fail++;
      $error("FAIL %s fault_code: got %0d want %0d", tag, fault_code, e.code);
    end
    n_checks++;
    assert (flash_red === e.flash) else begin
      n_fail++;
      $error("FAIL %s flash_red: got %0b want %0b", tag, flash_red, e.flash);
    end
    n_checks++;
    assert (main_cycles === e.cycles) else begin
      n_fail++;
      $error("FAIL %s main_cycles: got %0d want %0d", tag, main_cycles, e.cycles);
    end
  endtask

  // Drive one cycle of lamps, record what the outputs must be after the edge, then compare.
  task automatic step(input logic [2:0] m, input logic [2:0] s, input logic clr,
                      input logic ef, input logic [2:0] ec, input string tag);
    {main_R, main_G, main_Y} = m;
    {side_R, side_G, side_Y} = s;
    clear_fault = clr;
    push_exp(ef, ec);
    @(posedge clk_50);
    #1;
    check_out(tag);
  endtask

  initial begin
    reset = 1'b1;
    clear_fault = 1'b0;
    {main_R, main_G, main_Y} = LR;
    {side_R, side_G, side_Y} = LR;
    prev_fault = 1'b0;
    exp_cycles = 16'd0;
    #5;
    push_exp(1'b0, 3'd0);
    check_out("reset_values");
    @(posedge clk_50);
    @(posedge clk_50);
    #1;
    reset = 1'b0;

    // Legal full sequence, three rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(LG, LR, 1'b0, 1'b0, 3'd0, $sformatf("t1_main_g_r%0d", r));
      for (int i = 0; i < 4; i++)  step(LY, LR, 1'b0, 1'b0, 3'd0, $sformatf("t1_main_y_r%0d", r));
      exp_cycles = exp_cycles + 16'd1;
      step(LR, LR, 1'b0, 1'b0, 3'd0, $sformatf("t1_main_r_r%0d", r));
      for (int i = 0; i < 3; i++)  step(LR, LG, 1'b0, 1'b0, 3'd0, $sformatf("t1_side_g_r%0d", r));
      for (int i = 0; i < 5; i++)  step(LR, LY, 1'b0, 1'b0, 3'd0, $sformatf("t1_side_y_r%0d", r));
      step(LR, LR, 1'b0, 1'b0, 3'd0, $sformatf("t1_side_r_r%0d", r));
    end

    // Short main yellow.
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t2_g0");
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t2_g1");
    for (int i = 0; i < 3; i++) step(LY, LR, 1'b0, 1'b0, 3'd0, $sformatf("t2_y%0d", i));
    step(LR, LR, 1'b0, 1'b1, 3'd4, "t2_short_yel");
    step(LR, LR, 1'b0, 1'b1, 3'd4, "t2_flash");

    // Conflict: one cycle tolerated, two cycles fault.
    step(LR, LR, 1'b1, 1'b0, 3'd0, "t3_clear");
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t3_g0");
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t3_g1");
    step(LG, LG, 1'b0, 1'b0, 3'd0, "t3_conf_1cyc");
    step(LG, LG, 1'b0, 1'b1, 3'd1, "t3_conf_2cyc");
    // Conflict and an illegal main YEL->GRN on the same edge: conflict wins.
    step(LG, LG, 1'b1, 1'b0, 3'd0, "t3_clear2");
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t3_prio_g");
    step(LY, LR, 1'b0, 1'b0, 3'd0, "t3_prio_y");
    step(LY, LG, 1'b0, 1'b0, 3'd0, "t3_prio_conf1");
    step(LG, LG, 1'b0, 1'b1, 3'd1, "t3_prio_conf_vs_illegal");

    // Illegal side RED->YEL, then lamp glitches.
    step(LG, LR, 1'b1, 1'b0, 3'd0, "t4_clear");
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t4_capture");
    step(LG, LY, 1'b0, 1'b1, 3'd3, "t4_side_red_yel");
    step(LR, LR, 1'b1, 1'b0, 3'd0, "t4_clear2");
    step(LOFF, LR, 1'b0, 1'b0, 3'd0, "t4_dark0");
    step(LOFF, LR, 1'b0, 1'b0, 3'd0, "t4_dark1");
    step(LR, LR, 1'b0, 1'b0, 3'd0, "t4_dark_recover");
    step(LRY, LR, 1'b0, 1'b0, 3'd0, "t4_multi0");
    step(LRY, LR, 1'b0, 1'b0, 3'd0, "t4_multi1");
    step(LRY, LR, 1'b0, 1'b1, 3'd6, "t4_multi_fault");

    // Clear under a steady conflict re-faults after two cycles.
    step(LG, LG, 1'b0, 1'b1, 3'd6, "t5_frozen_code");
    step(LG, LG, 1'b1, 1'b0, 3'd0, "t5_clear");
    step(LG, LG, 1'b0, 1'b0, 3'd0, "t5_after_clear");
    step(LG, LG, 1'b0, 1'b1, 3'd1, "t5_refault");
    step(LY, LG, 1'b0, 1'b1, 3'd1, "t5_yel0");
    step(LY, LG, 1'b0, 1'b1, 3'd1, "t5_yel1");

    // Asynchronous reset mid-yellow.
    #9;
    reset = 1'b1;
    #1;
    exp_cycles = 16'd0;
    prev_fault = 1'b0;
    push_exp(1'b0, 3'd0);
    check_out("t5_async_reset");
    step(LY, LR, 1'b0, 1'b0, 3'd0, "t5_in_reset");
    reset = 1'b0;
    step(LY, LR, 1'b0, 1'b0, 3'd0, "t5_unk_yel0");
    step(LY, LR, 1'b0, 1'b0, 3'd0, "t5_unk_yel1");
    step(LR, LR, 1'b0, 1'b0, 3'd0, "t5_untimed_red");
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t5_post_g0");
    step(LG, LR, 1'b0, 1'b0, 3'd0, "t5_post_g1");
    for (int i = 0; i < 4; i++) step(LY, LR, 1'b0, 1'b0, 3'd0, $sformatf("t5_post_y%0d", i));
    exp_cycles = exp_cycles + 16'd1;
    step(LR, LR, 1'b0, 1'b0, 3'd0, "t5_post_cycle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
